// File: rtl/simd_register_bank.sv
// simd_register_bank: per-thread register files sharing one decoded instruction, with masked writeback and bulk clear.
// Define REGFILE_ZERO_REG_EN to make R0 a hardwired zero that silently drops writes.
module simd_register_bank #(
    parameter int THREADS   = 4,
    parameter int DATA_BITS = 8,
    parameter int NUM_REGS  = 16,
    parameter int ADDR_BITS = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [7:0]                   block_id,
    input  logic [2:0]                   core_state,
    input  logic [THREADS-1:0]           thread_mask,
    input  logic [ADDR_BITS-1:0]         decoded_rd_address,
    input  logic [ADDR_BITS-1:0]         decoded_rs_address,
    input  logic [ADDR_BITS-1:0]         decoded_rt_address,
    input  logic                         decoded_reg_write_enable,
    input  logic [1:0]                   decoded_reg_input_mux,
    input  logic [DATA_BITS-1:0]         decoded_immediate,
    input  logic [THREADS*DATA_BITS-1:0] alu_out,
    input  logic [THREADS*DATA_BITS-1:0] lsu_out,
    input  logic                         clear_req,
    output logic                         clear_busy,
    output logic                         write_error,
    output logic [THREADS*DATA_BITS-1:0] rs,
    output logic [THREADS*DATA_BITS-1:0] rt
);
    localparam int WR = NUM_REGS - 3;
    localparam logic [2:0] REQUEST = 3'b011;
    localparam logic [2:0] UPDATE  = 3'b110;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                       state_q;
    logic [ADDR_BITS-1:0]         idx_q;
    logic [DATA_BITS-1:0]         wr_q [THREADS][WR];
    logic [DATA_BITS-1:0]         blk_q;
    logic [DATA_BITS-1:0]         rf   [THREADS][NUM_REGS];
    logic [THREADS*DATA_BITS-1:0] rs_q, rt_q, rs_d, rt_d, wdata_d;
    logic                         write_error_q, err_d;
    logic                         req, upd, wr_attempt, rd_ro, zero_drop, do_write;

    assign req        = enable && state_q == IDLE && core_state == REQUEST;
    assign upd        = enable && state_q == IDLE && core_state == UPDATE;
    assign wr_attempt = upd && decoded_reg_write_enable && decoded_reg_input_mux != 2'b11;
    assign rd_ro      = decoded_rd_address >= ADDR_BITS'(WR);
`ifdef REGFILE_ZERO_REG_EN
    // R0 is never written, so its storage stays at its reset/clear value of zero
    assign zero_drop  = decoded_rd_address == '0;
`else
    assign zero_drop  = 1'b0;
`endif
    assign do_write   = wr_attempt && !rd_ro && !zero_drop;
    assign err_d      = wr_attempt && rd_ro;

    // Architectural view: writable storage followed by block id, thread count and thread index
    for (genvar t = 0; t < THREADS; t++) begin : g_t
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_r
            if (r < WR) begin : g_w
                assign rf[t][r] = wr_q[t][r];
            end else if (r == WR) begin : g_b
                assign rf[t][r] = blk_q;
            end else if (r == WR + 1) begin : g_n
                assign rf[t][r] = DATA_BITS'(THREADS);
            end else begin : g_i
                assign rf[t][r] = DATA_BITS'(t);
            end
        end
    end

    always_comb begin
        rs_d    = rs_q;
        rt_d    = rt_q;
        wdata_d = '0;
        for (int t = 0; t < THREADS; t++) begin
            if (req) begin
                rs_d[t*DATA_BITS +: DATA_BITS] = rf[t][decoded_rs_address];
                rt_d[t*DATA_BITS +: DATA_BITS] = rf[t][decoded_rt_address];
            end
            wdata_d[t*DATA_BITS +: DATA_BITS] =
                decoded_reg_input_mux == 2'b00 ? alu_out[t*DATA_BITS +: DATA_BITS] :
                decoded_reg_input_mux == 2'b01 ? lsu_out[t*DATA_BITS +: DATA_BITS] :
                decoded_immediate;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            blk_q         <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            write_error_q <= 1'b0;
            for (int t = 0; t < THREADS; t++)
                for (int r = 0; r < WR; r++)
                    wr_q[t][r] <= '0;
        end else begin
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            write_error_q <= err_d;
            if (enable)
                blk_q <= DATA_BITS'(block_id);
            // The clear sequencer keeps running even while the core is disabled
            if (state_q == CLEAR) begin
                for (int t = 0; t < THREADS; t++)
                    wr_q[t][idx_q] <= '0;
                idx_q <= idx_q + ADDR_BITS'(1);
                if (idx_q == ADDR_BITS'(WR - 1))
                    state_q <= IDLE;
            end else if (clear_req) begin
                state_q <= CLEAR;
                idx_q   <= '0;
            end
            for (int t = 0; t < THREADS; t++)
                if (do_write && thread_mask[t])
                    wr_q[t][decoded_rd_address] <= wdata_d[t*DATA_BITS +: DATA_BITS];
        end
    end

    assign clear_busy  = state_q == CLEAR;
    assign write_error = write_error_q;
    assign rs          = rs_q;
    assign rt          = rt_q;

endmodule

// File: tb/tb_simd_register_bank.sv
// tb_simd_register_bank: vector table plus scoreboarded clear and reset sequences for simd_register_bank.
module tb_simd_register_bank;
    localparam int T = 4, D = 8, N = 16, A = 4, WR = N - 3;
    localparam logic [2:0] REQ = 3'b011, UPD = 3'b110, NOP = 3'b000;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, enable, clear_req, we, clear_busy, write_error;
    logic [7:0] block_id;
    logic [2:0] core_state;
    logic [T-1:0] mask;
    logic [A-1:0] rd_a, rs_a, rt_a;
    logic [1:0] mux;
    logic [D-1:0] imm;
    logic [T*D-1:0] alu, lsu, rs, rt;

    always #5 clk = ~clk;

    simd_register_bank dut (
        .clk(clk), .reset(reset), .enable(enable), .block_id(block_id),
        .core_state(core_state), .thread_mask(mask),
        .decoded_rd_address(rd_a), .decoded_rs_address(rs_a), .decoded_rt_address(rt_a),
        .decoded_reg_write_enable(we), .decoded_reg_input_mux(mux),
        .decoded_immediate(imm), .alu_out(alu), .lsu_out(lsu),
        .clear_req(clear_req), .clear_busy(clear_busy), .write_error(write_error),
        .rs(rs), .rt(rt)
    );

    typedef struct packed {
        logic en; logic [2:0] st; logic [3:0] mask, rd, ra, rb; logic we; logic [1:0] mux;
        logic [7:0] imm; logic [31:0] alu, lsu; logic [7:0] blk; logic [31:0] ers, ert; logic eerr;
    } vec_t;
    typedef struct { logic [31:0] rs, rt; logic err; } exp_t;

    int checks = 0, errors = 0;
    logic [D-1:0] m [T][WR];
    logic [D-1:0] blk_m;
    logic [31:0] hold_rs, hold_rt;
    bit mclr;
    int midx;
    exp_t sb[$];
    vec_t tab [20];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input int r);
        logic [31:0] v;
        for (int t = 0; t < T; t++)
            v[t*D +: D] = r < WR ? m[t][r] : r == WR ? blk_m : r == WR + 1 ? 8'(T) : 8'(t);
        return v;
    endfunction

    function automatic vec_t mk(input logic en, input logic [2:0] st, input logic [3:0] mk_mask, mk_rd, ra, rb,
                                input logic mk_we, input logic [1:0] mk_mux, input logic [7:0] mk_imm,
                                input logic [31:0] mk_alu, mk_lsu, input logic [7:0] blk,
                                input logic [31:0] ers, ert, input logic eerr);
        return '{en, st, mk_mask, mk_rd, ra, rb, mk_we, mk_mux, mk_imm, mk_alu, mk_lsu, blk, ers, ert, eerr};
    endfunction

    task automatic drive(input logic en, input logic [2:0] st, input logic [3:0] msk, input logic [3:0] rd,
                         input logic [3:0] ra, input logic [3:0] rb, input logic w, input logic [1:0] mx,
                         input logic [7:0] im, input logic [7:0] blk, input logic cr);
        enable = en; core_state = st; mask = msk; rd_a = rd; rs_a = ra; rt_a = rb;
        we = w; mux = mx; imm = im; block_id = blk; clear_req = cr;
    endtask

    // Model the coming edge, queue the expectation, clock, then pop and compare
    task automatic step(input bit use_tab, input logic [31:0] trs, input logic [31:0] trt,
                        input logic terr, input string nm);
        exp_t e, got;
        e.rs = hold_rs; e.rt = hold_rt; e.err = 1'b0;
        if (!mclr && enable && core_state == REQ) begin
            e.rs = lanes(int'(rs_a));
            e.rt = lanes(int'(rt_a));
        end
        if (!mclr && enable && core_state == UPD && we && mux != 2'b11) begin
            if (rd_a >= 4'(WR)) e.err = 1'b1;
            else if (!(ZR && rd_a == 0))
                for (int t = 0; t < T; t++)
                    if (mask[t]) m[t][rd_a] = mux == 2'b00 ? alu[t*D +: D] : mux == 2'b01 ? lsu[t*D +: D] : imm;
        end
        if (enable) blk_m = block_id;
        if (mclr) begin
            for (int t = 0; t < T; t++) m[t][midx] = '0;
            if (midx == WR - 1) mclr = 0;
            midx++;
        end else if (clear_req) begin
            mclr = 1;
            midx = 0;
        end
        hold_rs = e.rs; hold_rt = e.rt;
        if (use_tab) begin
            e.rs = trs; e.rt = trt; e.err = terr;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({nm, " rs"}, rs, got.rs);
        check({nm, " rt"}, rt, got.rt);
        check({nm, " write_error"}, 32'(write_error), 32'(got.err));
        check({nm, " clear_busy"}, 32'(clear_busy), 32'(mclr));
    endtask

    task automatic model_reset();
        for (int t = 0; t < T; t++)
            for (int r = 0; r < WR; r++) m[t][r] = '0;
        blk_m = '0; hold_rs = '0; hold_rt = '0; mclr = 0; midx = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] r0v;
        int n;
        r0v = ZR ? 32'h0 : 32'h55555555;
        tab[0]  = mk(1, REQ, 4'hF, 0, 15, 14, 0, 3, 0, 0, 0, 8'h2A, 32'h03020100, 32'h04040404, 0);
        tab[1]  = mk(1, REQ, 4'hF, 0, 13, 15, 0, 3, 0, 0, 0, 8'h2A, 32'h2A2A2A2A, 32'h03020100, 0);
        tab[2]  = mk(1, UPD, 4'b0101, 3, 0, 0, 1, 0, 0, 32'h44332211, 0, 8'h2A, 32'h2A2A2A2A, 32'h03020100, 0);
        tab[3]  = mk(1, REQ, 4'hF, 0, 3, 13, 0, 3, 0, 0, 0, 8'h2A, 32'h00330011, 32'h2A2A2A2A, 0);
        tab[4]  = mk(1, UPD, 4'hF, 14, 0, 0, 1, 2, 8'hFF, 0, 0, 8'h2A, 32'h00330011, 32'h2A2A2A2A, 1);
        tab[5]  = mk(1, REQ, 4'hF, 0, 14, 3, 0, 3, 0, 0, 0, 8'h2A, 32'h04040404, 32'h00330011, 0);
        tab[6]  = mk(1, UPD, 4'hF, 5, 0, 0, 1, 1, 0, 0, 32'hDDCCBBAA, 8'h2A, 32'h04040404, 32'h00330011, 0);
        tab[7]  = mk(1, UPD, 4'hF, 5, 0, 0, 1, 3, 8'h77, 32'h12345678, 32'h12345678, 8'h2A, 32'h04040404, 32'h00330011, 0);
        tab[8]  = mk(1, UPD, 4'hF, 6, 0, 0, 0, 2, 8'h77, 0, 0, 8'h2A, 32'h04040404, 32'h00330011, 0);
        tab[9]  = mk(1, UPD, 4'b1010, 6, 0, 0, 1, 2, 8'h99, 0, 0, 8'h2A, 32'h04040404, 32'h00330011, 0);
        tab[10] = mk(1, REQ, 4'hF, 0, 5, 6, 0, 3, 0, 0, 0, 8'h2A, 32'hDDCCBBAA, 32'h99009900, 0);
        tab[11] = mk(1, UPD, 4'hF, 0, 0, 0, 1, 2, 8'h55, 0, 0, 8'h2A, 32'hDDCCBBAA, 32'h99009900, 0);
        tab[12] = mk(1, REQ, 4'hF, 0, 0, 12, 0, 3, 0, 0, 0, 8'h2A, r0v, 32'h0, 0);
        tab[13] = mk(1, UPD, 4'hF, 13, 0, 0, 1, 0, 0, 32'h01010101, 0, 8'h2A, r0v, 32'h0, 1);
        tab[14] = mk(1, UPD, 4'b0000, 15, 0, 0, 1, 1, 0, 0, 0, 8'h2A, r0v, 32'h0, 1);
        tab[15] = mk(1, UPD, 4'hF, 12, 0, 0, 1, 0, 0, 32'h0C0B0A09, 0, 8'h2A, r0v, 32'h0, 0);
        tab[16] = mk(0, REQ, 4'hF, 0, 12, 13, 0, 3, 0, 0, 0, 8'h77, r0v, 32'h0, 0);
        tab[17] = mk(1, REQ, 4'hF, 0, 12, 13, 0, 3, 0, 0, 0, 8'h2A, 32'h0C0B0A09, 32'h2A2A2A2A, 0);
        tab[18] = mk(0, UPD, 4'hF, 3, 0, 0, 1, 2, 8'hEE, 0, 0, 8'h2A, 32'h0C0B0A09, 32'h2A2A2A2A, 0);
        tab[19] = mk(1, REQ, 4'hF, 0, 3, 15, 0, 3, 0, 0, 0, 8'h2A, 32'h00330011, 32'h03020100, 0);

        alu = '0; lsu = '0;
        drive(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset rs", rs, 32'h0);
        check("reset rt", rt, 32'h0);
        check("reset clear_busy", 32'(clear_busy), 32'h0);
        check("reset write_error", 32'(write_error), 32'h0);

        for (int i = 0; i < 20; i++) begin
            drive(tab[i].en, tab[i].st, tab[i].mask, tab[i].rd, tab[i].ra, tab[i].rb,
                  tab[i].we, tab[i].mux, tab[i].imm, tab[i].blk, 0);
            alu = tab[i].alu; lsu = tab[i].lsu;
            step(1, tab[i].ers, tab[i].ert, tab[i].eerr, $sformatf("vec%0d", i));
        end

        for (int r = 0; r < WR; r++) begin
            drive(1, UPD, 4'hF, 4'(r), 0, 0, 1, 2, 8'hAA, 8'h2A, 0);
            step(0, 0, 0, 0, $sformatf("load%0d", r));
        end
        drive(1, REQ, 4'hF, 0, 13, 14, 0, 3, 0, 8'h2A, 0);
        step(0, 0, 0, 0, "preclear");
        drive(1, NOP, 4'hF, 0, 0, 0, 0, 3, 0, 8'h5A, 1);
        step(0, 0, 0, 0, "clear_start");
        n = 0;
        while (clear_busy && n < 40) begin
            if (n % 3 == 0)      drive(1, UPD, 4'hF, 1, 0, 0, 1, 2, 8'h11, 8'h5A, n == 4);
            else if (n % 3 == 1) drive(1, REQ, 4'hF, 0, 15, 0, 0, 3, 0, 8'h5A, n == 4);
            else                 drive(1, UPD, 4'hF, 14, 0, 0, 1, 2, 8'h00, 8'h5A, n == 4);
            step(0, 0, 0, 0, $sformatf("midclear%0d", n));
            n++;
        end
        check("clear_len", 32'(n), 32'd13);
        for (int r = 0; r < N; r++) begin
            drive(1, REQ, 4'hF, 0, 4'(r), 4'(N - 1 - r), 0, 3, 0, 8'h5A, 0);
            step(0, 0, 0, 0, $sformatf("postclear%0d", r));
        end

        drive(1, NOP, 4'hF, 0, 0, 0, 0, 3, 0, 8'h5A, 1);
        step(0, 0, 0, 0, "abort_start");
        drive(1, NOP, 4'hF, 0, 0, 0, 0, 3, 0, 8'h5A, 0);
        step(0, 0, 0, 0, "abort_run0");
        step(0, 0, 0, 0, "abort_run1");
        #2 reset = 1'b1;
        #1;
        check("abort clear_busy", 32'(clear_busy), 32'h0);
        check("abort rs", rs, 32'h0);
        check("abort rt", rt, 32'h0);
        model_reset();
        #3 reset = 1'b0;
        drive(1, REQ, 4'hF, 0, 14, 13, 0, 3, 0, 8'h33, 0);
        step(0, 0, 0, 0, "after_reset0");
        drive(1, REQ, 4'hF, 0, 3, 13, 0, 3, 0, 8'h33, 0);
        step(0, 0, 0, 0, "after_reset1");
        check("scoreboard empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/simd_register_bank.md
# simd_register_bank

Per-core SIMD register bank holding one private register file for each of `THREADS` threads. All threads share one decoded instruction. It captures `rs`/`rt` operands for every thread in the REQUEST state and writes back per-thread results in the UPDATE state, gated by an active-thread mask. It also provides a multi-cycle bulk-clear sequencer, and sits between the decoder/scheduler and the per-thread ALU/LSU lanes.

## Interface
Parameters:
- `THREADS`, 4, thread lanes per core.
- `DATA_BITS`, 8, register width.
- `NUM_REGS`, 16, registers per thread; power of two, ≥8.
- `ADDR_BITS`, $clog2(NUM_REGS), register address width.

Ports:
- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  core enable.
- `block_id`  in  8  current block; zero-extended or truncated to `DATA_BITS`.
- `core_state`  in  3  REQUEST=3'b011, UPDATE=3'b110.
- `thread_mask`  in  THREADS  bit t=1 means thread t is active.
- `decoded_rd_address`, `decoded_rs_address`, `decoded_rt_address`  in  ADDR_BITS each.
- `decoded_reg_write_enable`  in  1.
- `decoded_reg_input_mux`  in  2  00 ALU, 01 LSU, 10 immediate, 11 no write.
- `decoded_immediate`  in  DATA_BITS.
- `alu_out`, `lsu_out`  in  THREADS*DATA_BITS  lane t at bits [t*DATA_BITS +: DATA_BITS].
- `clear_req`  in  1  request bulk clear of writable registers.
- `clear_busy`  out  1  clear sequence in progress.
- `write_error`  out  1  one-cycle pulse on an attempted write to a read-only register.
- `rs`, `rt`  out  THREADS*DATA_BITS  per-lane operands.

## Operation
- Read-only registers per thread t:
  - R[NUM_REGS-3] = block_id.
  - R[NUM_REGS-2] = THREADS.
  - R[NUM_REGS-1] = t.
- Writable registers: R0..R[NUM_REGS-4].
- Reset: all registers 0, except R[NUM_REGS-2]=THREADS and R[NUM_REGS-1]=t. Outputs: `rs`=`rt`=0, `clear_busy`=0, `write_error`=0. FSM goes to IDLE.
- The block_id register loads `block_id` on every cycle with `enable`=1, including during CLEAR.
- FSM state IDLE, with `enable`=1:
  - REQUEST: every lane loads `rs`/`rt` from its own file, regardless of mask.
  - UPDATE with write_enable, mux≠11, rd < NUM_REGS-3: each lane with its mask bit set writes its ALU lane, LSU lane, or immediate.
  - UPDATE with write_enable, mux≠11, rd ≥ NUM_REGS-3: no write; `write_error` pulses.
- FSM transition IDLE→CLEAR: `clear_req`=1, independent of `enable`. Index counter set to 0.
- FSM state CLEAR:
  - Each cycle zeroes R[index] in all threads and increments the index.
  - After zeroing R[NUM_REGS-4], returns to IDLE.
  - REQUEST and UPDATE are ignored: `rs`/`rt` hold, no writes, no `write_error`.
  - `clear_req` is ignored.
- `clear_busy` = (state == CLEAR).
- An `enable`=0 cycle freezes everything except the clear sequencer.
- Reset during CLEAR aborts to IDLE with reset values.

## Timing
- `rs`/`rt` are valid the cycle after the REQUEST edge; 1-cycle latency.
- A write commits at the UPDATE-cycle edge and is visible to a REQUEST in any later cycle. No same-cycle forwarding (the states are exclusive).
- `clear_busy` rises the cycle after `clear_req` is sampled and stays high exactly NUM_REGS-3 cycles.
- `write_error` is registered: high the cycle after the offending UPDATE, for 1 cycle.

## Configuration
- `REGFILE_ZERO_REG_EN` defined:
  - R0 always reads 0.
  - Writes to R0 are silently dropped, with no `write_error`.
  - CLEAR behaviour is unchanged.
- Undefined: R0 is an ordinary writable register.

## Test plan
- Reset, then REQUEST rs=15, rt=14 (NUM_REGS=16, THREADS=4) -> lane t: `rs`=t, `rt`=4.
- `block_id`=8'h2A, REQUEST rs=13 -> all lanes `rs`=8'h2A.
- UPDATE rd=3, mux=00, `alu_out`={8'h44,8'h33,8'h22,8'h11}, mask=4'b0101, then REQUEST rs=3 -> `rs`={8'h00,8'h33,8'h00,8'h11}.
- UPDATE rd=14, mux=10, imm=8'hFF -> `write_error` high for 1 cycle; subsequent REQUEST rs=14 still reads 4.
- Load R0..R12 with 8'hAA, pulse `clear_req`, then issue UPDATE/REQUEST mid-clear -> `clear_busy` high for 13 cycles, no writes and `rs` held; afterwards all of R0..R12 read 0 and R13..R15 are unchanged.
- With `REGFILE_ZERO_REG_EN`: UPDATE rd=0, imm=8'h55, then REQUEST rs=0 -> `rs`=0, no `write_error`. Assert reset mid-clear -> `clear_busy`=0 immediately (asynchronous).
